// File: rtl/iob_master_if.sv
// I/O bus master signal bundle: bridge-side request handshake plus the
// 68000-style asynchronous bus strobes and responses.
interface iob_master_if;
  logic IOREQ, IORW, IOL, IOU;
  logic IOACT, IOBERR, IODinLE, nDoutOE;
  logic nAS, nLDS, nUDS, nWE, nVMA, E;
  logic nDTACK, nBERR, nVPA;

  modport master (
    input  IOREQ, IORW, IOL, IOU, nDTACK, nBERR, nVPA,
    output IOACT, IOBERR, IODinLE, nDoutOE, nAS, nLDS, nUDS, nWE, nVMA, E
  );

  modport slave (
    output IOREQ, IORW, IOL, IOU, nDTACK, nBERR, nVPA,
    input  IOACT, IOBERR, IODinLE, nDoutOE, nAS, nLDS, nUDS, nWE, nVMA, E
  );
endinterface

// File: rtl/iob_master.sv
// I/O bus master: runs one 68000-style async cycle per IOREQ, terminated by
// DTACK, BERR, timeout or a 6800 VPA/VMA cycle locked to a local E clock.
module iob_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic          CLK,
  input logic          nRST,
  iob_master_if.master bus
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_WAIT, ST_VPAW, ST_VMA, ST_END
  } st_t;

  typedef struct packed {
    logic rw;
    logic l;
    logic u;
  } req_t;

  st_t        st, st_n;
  req_t       req, req_n;
  logic [7:0] tcnt, tcnt_n;
  logic [3:0] ecnt, ecnt_n;
  logic       e;
  logic       dtack_r, berr_r, vpa_r;

  logic ioact, ioact_n, ioberr, ioberr_n, dinle, dinle_n, ndoutoe, ndoutoe_n;
  logic nas, nas_n, nlds, nlds_n, nuds, nuds_n, nwe, nwe_n, nvma, nvma_n;
  logic do_end, end_err;

  // E clock: free-running divide-by-10, high for Ecnt 6..9. E is registered
  // from the next count so it tracks Ecnt exactly.
  assign ecnt_n = (ecnt == 4'd9) ? 4'd0 : ecnt + 4'd1;

  always_comb begin
    st_n      = st;
    req_n     = req;
    tcnt_n    = tcnt;
    ioact_n   = ioact;
    ioberr_n  = ioberr;
    dinle_n   = dinle;
    ndoutoe_n = ndoutoe;
    nas_n     = nas;
    nlds_n    = nlds;
    nuds_n    = nuds;
    nwe_n     = nwe;
    nvma_n    = nvma;
    do_end    = 1'b0;
    end_err   = 1'b0;
    case (st)
      ST_IDLE: if (bus.IOREQ) begin
        req_n    = '{rw: bus.IORW, l: bus.IOL, u: bus.IOU};
        ioact_n  = 1'b1;
        ioberr_n = 1'b0;
        st_n     = ST_S1;
      end
      ST_S1: begin
        nwe_n = req.rw;
        st_n  = ST_S2;
      end
      ST_S2: begin
        nas_n = 1'b0;
        if (req.rw) begin
          nlds_n = ~req.l;
          nuds_n = ~req.u;
        end else begin
          ndoutoe_n = 1'b0;
        end
        tcnt_n = 8'd0;
        st_n   = ST_S3;
      end
      ST_S3: begin
        // write data gets a cycle of setup before the data strobes
        if (!req.rw) begin
          nlds_n = ~req.l;
          nuds_n = ~req.u;
        end
        st_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (berr_r) begin
          do_end  = 1'b1;
          end_err = 1'b1;
        end else if (dtack_r) begin
          do_end = 1'b1;
        end else if (vpa_r) begin
          st_n = ST_VPAW;
        end else if (tcnt == TIMEOUT) begin
          do_end  = 1'b1;
          end_err = 1'b1;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      // Checked one count early so nVMA falls as Ecnt enters 2.
      ST_VPAW: if (ecnt == 4'd1) begin
        nvma_n = 1'b0;
        st_n   = ST_VMA;
      end
      ST_VMA: begin
        if (berr_r) begin
          do_end  = 1'b1;
          end_err = 1'b1;
        end else if (ecnt == 4'd9) begin
          do_end = 1'b1;
        end
      end
      ST_END: begin
        dinle_n   = 1'b0;
        ndoutoe_n = 1'b1;
        nwe_n     = 1'b1;
        st_n      = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
    if (do_end) begin
      st_n     = ST_END;
      nas_n    = 1'b1;
      nlds_n   = 1'b1;
      nuds_n   = 1'b1;
      nvma_n   = 1'b1;
      ioact_n  = 1'b0;
      ioberr_n = end_err;
      dinle_n  = req.rw & ~end_err;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st      <= ST_IDLE;
      req     <= '0;
      tcnt    <= 8'd0;
      ecnt    <= 4'd0;
      e       <= 1'b0;
      dtack_r <= 1'b0;
      berr_r  <= 1'b0;
      vpa_r   <= 1'b0;
      ioact   <= 1'b0;
      ioberr  <= 1'b0;
      dinle   <= 1'b0;
      ndoutoe <= 1'b1;
      nas     <= 1'b1;
      nlds    <= 1'b1;
      nuds    <= 1'b1;
      nwe     <= 1'b1;
      nvma    <= 1'b1;
    end else begin
      st      <= st_n;
      req     <= req_n;
      tcnt    <= tcnt_n;
      ecnt    <= ecnt_n;
      e       <= (ecnt_n >= 4'd6);
      dtack_r <= ~bus.nDTACK;
      berr_r  <= ~bus.nBERR;
      vpa_r   <= ~bus.nVPA;
      ioact   <= ioact_n;
      ioberr  <= ioberr_n;
      dinle   <= dinle_n;
      ndoutoe <= ndoutoe_n;
      nas     <= nas_n;
      nlds    <= nlds_n;
      nuds    <= nuds_n;
      nwe     <= nwe_n;
      nvma    <= nvma_n;
    end
  end

  assign bus.IOACT   = ioact;
  assign bus.IOBERR  = ioberr;
  assign bus.IODinLE = dinle;
  assign bus.nDoutOE = ndoutoe;
  assign bus.nAS     = nas;
  assign bus.nLDS    = nlds;
  assign bus.nUDS    = nuds;
  assign bus.nWE     = nwe;
  assign bus.nVMA    = nvma;
  assign bus.E       = e;
endmodule

// File: doc/iob_master.md
# iob_master

I/O bus master controller. It accepts one transfer request at a time from the FSB-side I/O bridge slave over the IOREQ/IOACT handshake and runs the corresponding MC68000-style asynchronous cycle on the I/O bus. It terminates each cycle on DTACK, BERR, timeout, or a 6800-style VPA/VMA cycle synchronized to a locally generated E clock. Reports completion back by dropping IOACT.

## Interface
Parameters:
- TIMEOUT, 255: WAIT-state cycles without termination before forced bus error (8-bit, 1..255).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous to CLK, active-low.
- IOREQ  in  1  transfer request from slave, level.
- IORW  in  1  direction; 1 = read, 0 = write. Same polarity as nWE.
- IOL  in  1  lower byte lane requested.
- IOU  in  1  upper byte lane requested.
- IOACT  out  1  cycle accepted/in progress.
- IOBERR  out  1  last cycle ended in bus error or timeout; valid while IOACT=0, cleared on next accept.
- IODinLE  out  1  one-cycle read-data latch enable.
- nDoutOE  out  1  write-data output enable, active-low.
- nAS, nLDS, nUDS, nWE  out  1 each  I/O bus strobes, active-low.
- nVMA  out  1  valid memory address, 6800 cycles.
- E  out  1  6800 E clock.
- nDTACK, nBERR, nVPA  in  1 each  asynchronous I/O bus responses, active-low.

## Operation
- nDTACK, nBERR, and nVPA each pass through one register stage (DTACKr, BERRr, VPAr). Only the registered copies are used.
- E generator:
  - 4-bit Ecnt counts 0..9, then wraps to 0.
  - E=1 when Ecnt is 6..9; E is registered.
  - Free-running; never stalled by bus activity.
- All outputs are registered. Each takes its new value on the edge that enters a state.
- IDLE:
  - If IOREQ=1, capture IORW/IOL/IOU into RWq/Lq/Uq, set IOACT=1, clear IOBERR, go to S1.
  - Otherwise stay in IDLE.
- S1: nWE=RWq. Go to S2.
- S2:
  - nAS=0.
  - Read: nLDS=~Lq, nUDS=~Uq.
  - Write: nDoutOE=0.
  - Clear the timeout counter. Go to S3.
- S3: write only, nLDS=~Lq, nUDS=~Uq. Go to WAIT.
- WAIT, priority order:
  1. BERRr → END, IOBERR=1.
  2. DTACKr → END.
  3. VPAr → VPAW.
  4. Counter reaches TIMEOUT → END, IOBERR=1.
  5. Otherwise increment the counter.
- VPAW: when Ecnt=2, nVMA=0 and go to VMA. The timeout counter is frozen in VPAW and VMA.
- VMA: when Ecnt=9, go to END (strobes negate as E falls). BERRr in VMA → END with IOBERR=1.
- On entering END:
  - nAS=nLDS=nUDS=1, nVMA=1, IOACT=0.
  - IODinLE=1 if RWq=1 and no error.
- END (one cycle):
  - IODinLE=0, nDoutOE=1, nWE=1.
  - Go to IDLE. IOREQ is not sampled during END.
- A request with IOL=IOU=0 still runs a full cycle with nAS only.
- Reset: all states forced to IDLE, Ecnt=0.
  - Reset values: IOACT=0, IOBERR=0, IODinLE=0, E=0, and nDoutOE/nAS/nLDS/nUDS/nWE/nVMA=1.
  - Reset mid-cycle negates all strobes on the reset edge, with no END pulse and no IODinLE.

## Timing
- Notation: request sampled at edge k.
  - IOACT=1 after k.
  - nWE valid after k+1.
  - nAS and read strobes low after k+2.
  - Write strobes low after k+3.
  - Earliest WAIT is after k+3.
- Termination:
  - nDTACK low before edge m → DTACKr after m.
  - If in WAIT, END is entered at m+1: strobes high, IOACT low.
  - Idle at m+2. Minimum cycle is 6 clocks, IOREQ to IDLE.
- Handshake rules:
  - The slave holds IOREQ until it observes IOACT, then deasserts.
  - IOREQ must be low by the END edge. IOACT-low to next acceptance is at least 2 clocks.
  - A new IOREQ is accepted only after IOACT has been low one full cycle.
- VPA cycles:
  - nVMA falls at an Ecnt 1→2 boundary and rises with E falling, at Ecnt 9→0.
  - Latency ranges from one to two E periods after VPAr.
- Simultaneous BERRr+DTACKr: error wins.
- Timeout: TIMEOUT+1 WAIT cycles after WAIT entry.

## Test plan
- Reset mid-write (nRST=0 while nAS=0) → next edge all strobes=1, nDoutOE=1, IOACT=0, E=0. No IODinLE pulse.
- Read, IOL=1, IOU=0, nDTACK tied low → nAS/nLDS low at k+2, nUDS stays high. IODinLE single pulse, IOACT low at k+4, IOBERR=0.
- Write, IOL=IOU=1, nDTACK low 3 clocks after nAS → nDoutOE low from k+2, strobes from k+3. nWE=0 throughout, all negated together with IOACT.
- nBERR and nDTACK asserted on the same edge in a read → IOBERR=1, no IODinLE, IOACT drops the next edge.
- nVPA asserted, no DTACK → nVMA low only with Ecnt=2..9 of one E period. END coincides with E falling, read IODinLE pulse on the END entry.
- TIMEOUT=4, no response → END after exactly 5 WAIT cycles, IOBERR=1. An IOREQ held high across END is not re-accepted until 1 clock after IOACT=0.
